// File: rtl/fsm_job_pkg.sv
// fsm_job_pkg: state encoding and default timeout
// shared by the job arbiter and its picker.
package fsm_job_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/fsm_job_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set
// request at or after rr_ptr, wrapping modulo N_REQ.
module rr_pick
    import fsm_job_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    grant_idx,
    output logic             any_req
);

    logic [IW:0] w_pos;

    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        w_pos     = '0;
        // scan offsets high to low so the nearest set bit wins
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, rr_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N_REQ))
                w_pos = w_pos - (IW+1)'(N_REQ);
            if (req[w_pos[IW-1:0]]) begin
                grant_idx = w_pos[IW-1:0];
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_job_arbiter.sv
// fsm_job_arbiter: shares one start/done control FSM among
// N_REQ requesters with round-robin grant and timeout.
module fsm_job_arbiter
    import fsm_job_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         err,
    output logic                     fsm_start,
    input  logic                     fsm_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int IW = $clog2(N_REQ);

    state_t           r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic [TW-1:0]    r_cnt;
    logic             r_to;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_err;
    logic             r_start;
    logic             r_busy;
    logic [IW-1:0]    w_idx;
    logic             w_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req       (req),
        .rr_ptr    (r_ptr),
        .grant_idx (w_idx),
        .any_req   (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_to    <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_err   <= '0;
            r_start <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // a done still high from an earlier job must not start a new one
                    if (w_any && !fsm_done) begin
                        r_owner <= w_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                    r_to    <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (fsm_done) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                        r_to    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_to)
                        r_err[r_owner] <= 1'b1;
                    else
                        r_ack[r_owner] <= 1'b1;
                    r_ptr <= (r_owner == IW'(N_REQ - 1)) ? '0
                                                         : r_owner + 1'b1;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!fsm_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign fsm_start = r_start;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule
